// File: rtl/prt_pkg.sv
// Constants and FSM state type shared by the PRT table and the frame sender.
package prt_pkg;

   localparam int unsigned PrtIndexSize      = 2;
   localparam int unsigned PrtTableSize      = 4;
   localparam int unsigned PrtBramMemorySize = 1520;
   localparam int unsigned PrtBramAddrSize   = 16;
   localparam int unsigned PrtBramDataSize   = 8;

   typedef enum logic [1:0] {
      StIdle,
      StCheck,
      StStream,
      StFinish
   } prt_tx_state_e;

endpackage

// File: rtl/prt_skid_fifo.sv
// Two-entry FIFO holding {last, data} bytes returned from frame memory.
module prt_skid_fifo #(
   parameter int unsigned WIDTH = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_q == 2'd2);
   assign empty    = (count_q == 2'd0);
   assign do_pop   = pop && !empty;
   // A full FIFO may still take a byte when the head leaves in the same cycle.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (flush) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= !wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= !rd_ptr_q;
         end
         count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/prt_frame_sender.sv
// Streams a PRT slot's frame bytes from memory to a valid/ready sink, cut-through
// against the slot's growing byte count.
module prt_frame_sender
   import prt_pkg::*;
#(
   parameter int unsigned INDEX_SIZE       = PrtIndexSize,
   parameter int unsigned TABLE_SIZE       = PrtTableSize,
   parameter int unsigned BRAM_MEMORY_SIZE = PrtBramMemorySize,
   parameter int unsigned BRAM_ADDR_SIZE   = PrtBramAddrSize,
   parameter int unsigned BRAM_DATA_SIZE   = PrtBramDataSize
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   input  logic [INDEX_SIZE-1:0]     req_slot,
   output logic                      req_ready,
   output logic [INDEX_SIZE-1:0]     cur_slot,
   input  logic                      cur_valid,
   input  logic                      cur_fully_rcvd,
   input  logic [BRAM_ADDR_SIZE-1:0] cur_bytes_rcvd,
   output logic                      mem_rd_en,
   output logic [BRAM_ADDR_SIZE-1:0] mem_rd_addr,
   input  logic [BRAM_DATA_SIZE-1:0] mem_rd_data,
   output logic                      tx_valid,
   output logic [BRAM_DATA_SIZE-1:0] tx_data,
   output logic                      tx_last,
   input  logic                      tx_ready,
   output logic [BRAM_ADDR_SIZE-1:0] bytes_sent_res,
   output logic                      done_valid,
   output logic [INDEX_SIZE-1:0]     done_slot,
   output logic                      error
);

   prt_tx_state_e             state_q;
   logic [INDEX_SIZE-1:0]     cur_slot_q;
   logic [INDEX_SIZE-1:0]     done_slot_q;
   logic [BRAM_ADDR_SIZE-1:0] rd_ptr_q;
   logic [BRAM_ADDR_SIZE-1:0] sent_q;
   logic                      done_valid_q;
   logic                      error_q;
   logic                      inflight_q;
   logic                      inflight_last_q;

   logic [BRAM_ADDR_SIZE:0]   ptr_next;
   logic [BRAM_ADDR_SIZE:0]   bytes_ext;
   logic                      in_stream;
   logic                      too_long;
   logic                      abort;
   logic                      empty_frame;
   logic                      last_addr;
   logic                      avail;
   logic                      issue;
   logic                      tx_fire;
   logic [2:0]                used;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [BRAM_DATA_SIZE:0]   fifo_out;

   always_comb begin
      ptr_next    = {1'b0, rd_ptr_q} + {{BRAM_ADDR_SIZE{1'b0}}, 1'b1};
      bytes_ext   = {1'b0, cur_bytes_rcvd};
      in_stream   = (state_q == StStream);
      too_long    = 32'(cur_bytes_rcvd) > BRAM_MEMORY_SIZE;
      abort       = in_stream && (!cur_valid || too_long);
      empty_frame = in_stream && cur_fully_rcvd && (cur_bytes_rcvd == '0);
      // The newest received byte is withheld until the frame is complete.
      last_addr   = (ptr_next == bytes_ext);
      avail       = (ptr_next < bytes_ext) || (last_addr && cur_fully_rcvd);
      tx_valid    = !fifo_empty && !abort;
      tx_fire     = tx_valid && tx_ready;
      // Occupancy after this cycle's pop; keeps in-flight plus buffered within two.
      used        = {2'b00, inflight_q} + {1'b0, fifo_full, !fifo_full && !fifo_empty}
                    - {2'b00, tx_fire};
      issue       = in_stream && !abort && !empty_frame && avail && (used < 3'd2);
   end

   prt_skid_fifo #(
      .WIDTH (BRAM_DATA_SIZE + 1)
   ) u_skid_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (abort),
      .push      (inflight_q && !abort),
      .push_data ({inflight_last_q, mem_rd_data}),
      .pop       (tx_fire),
      .pop_data  (fifo_out),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= StIdle;
         cur_slot_q      <= '0;
         done_slot_q     <= '0;
         rd_ptr_q        <= '0;
         sent_q          <= '0;
         done_valid_q    <= 1'b0;
         error_q         <= 1'b0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         done_valid_q    <= 1'b0;
         error_q         <= 1'b0;
         inflight_q      <= issue;
         inflight_last_q <= issue && last_addr && cur_fully_rcvd;
         if (issue) begin
            rd_ptr_q <= ptr_next[BRAM_ADDR_SIZE-1:0];
         end
         if (tx_fire) begin
            sent_q <= sent_q + {{(BRAM_ADDR_SIZE-1){1'b0}}, 1'b1};
         end
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  cur_slot_q <= req_slot;
                  rd_ptr_q   <= '0;
                  sent_q     <= '0;
                  state_q    <= StCheck;
               end
            end
            StCheck: begin
               if (!cur_valid || (32'(cur_slot_q) >= TABLE_SIZE)) begin
                  error_q <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  state_q <= StStream;
               end
            end
            StStream: begin
               if (abort) begin
                  error_q <= 1'b1;
                  state_q <= StIdle;
               end else if (empty_frame) begin
                  error_q      <= 1'b1;
                  done_valid_q <= 1'b1;
                  done_slot_q  <= cur_slot_q;
                  state_q      <= StIdle;
               end else if (tx_fire && fifo_out[BRAM_DATA_SIZE]) begin
                  done_valid_q <= 1'b1;
                  done_slot_q  <= cur_slot_q;
                  state_q      <= StFinish;
               end
            end
            StFinish: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign req_ready      = (state_q == StIdle);
   assign cur_slot       = cur_slot_q;
   assign mem_rd_en      = issue;
   assign mem_rd_addr    = rd_ptr_q;
   assign tx_data        = tx_valid ? fifo_out[BRAM_DATA_SIZE-1:0] : '0;
   assign tx_last        = tx_valid && fifo_out[BRAM_DATA_SIZE];
   assign bytes_sent_res = sent_q;
   assign done_valid     = done_valid_q;
   assign done_slot      = done_slot_q;
   assign error          = error_q;

endmodule

// File: tb/tb_prt_frame_sender.sv
// Self-checking bench for prt_frame_sender: frame-level model plus directed and random frames.
module tb_prt_frame_sender;

   localparam int MaxBytes = 1520;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic [1:0]  req_slot = 2'd0;
   logic        req_ready;
   logic [1:0]  cur_slot;
   logic        cur_valid = 1'b0;
   logic        cur_fully_rcvd = 1'b0;
   logic [15:0] cur_bytes_rcvd = 16'd0;
   logic        mem_rd_en;
   logic [15:0] mem_rd_addr;
   logic [7:0]  mem_rd_data;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_last;
   logic        tx_ready;
   logic [15:0] bytes_sent_res;
   logic        done_valid;
   logic [1:0]  done_slot;
   logic        error;

   prt_frame_sender dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_slot       (req_slot),
      .req_ready      (req_ready),
      .cur_slot       (cur_slot),
      .cur_valid      (cur_valid),
      .cur_fully_rcvd (cur_fully_rcvd),
      .cur_bytes_rcvd (cur_bytes_rcvd),
      .mem_rd_en      (mem_rd_en),
      .mem_rd_addr    (mem_rd_addr),
      .mem_rd_data    (mem_rd_data),
      .tx_valid       (tx_valid),
      .tx_data        (tx_data),
      .tx_last        (tx_last),
      .tx_ready       (tx_ready),
      .bytes_sent_res (bytes_sent_res),
      .done_valid     (done_valid),
      .done_slot      (done_slot),
      .error          (error)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Frame memory: one-cycle read latency, garbage when not read.
   logic [7:0] frame_mem [MaxBytes];
   always @(posedge clk) begin
      if (mem_rd_en && (32'(mem_rd_addr) < MaxBytes)) mem_rd_data <= frame_mem[mem_rd_addr[10:0]];
      else mem_rd_data <= 8'($urandom);
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int ready_mode = 0;
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tx_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
   end

   // Frame expectation set by the stimulus; monitor state owned by the monitor.
   int   exp_len = 0;
   bit   clr_req = 1'b0;
   bit   clr_ack = 1'b0;
   int   beat_idx, n_last, n_done, n_err, n_reads, rd_expect;
   int   first_valid_cyc, first_beat_cyc, last_beat_cyc, done_cyc, err_cyc;
   logic [1:0] last_done_slot;
   logic [7:0] last_data;
   bit   prev_stall;
   logic [7:0] prev_data;
   logic prev_last;
   int   rd_next, rcvd_now;

   always @(negedge clk) begin
      if (clr_req != clr_ack) begin
         beat_idx = 0; n_last = 0; n_done = 0; n_err = 0; n_reads = 0; rd_expect = 0;
         first_valid_cyc = -1; first_beat_cyc = -1; last_beat_cyc = -1;
         done_cyc = -1; err_cyc = -2; last_done_slot = 2'd0; last_data = 8'd0;
         clr_ack = clr_req;
      end
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && cur_valid) begin
            chk("hold_valid", 32'(tx_valid), 32'd1);
            chk("hold_data", 32'(tx_data), 32'(prev_data));
            chk("hold_last", 32'(tx_last), 32'(prev_last));
         end
         if (mem_rd_en) begin
            rd_next  = int'(mem_rd_addr) + 1;
            rcvd_now = int'(cur_bytes_rcvd);
            chk("rd_addr_order", 32'(mem_rd_addr), 32'(rd_expect));
            chk("rd_addr_available",
                32'((rd_next < rcvd_now) || (rd_next == rcvd_now && cur_fully_rcvd)), 32'd1);
            rd_expect++;
            n_reads++;
         end
         if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (tx_valid && tx_ready) begin
            if (beat_idx < exp_len) begin
               chk("tx_data", 32'(tx_data), 32'(frame_mem[beat_idx]));
               chk("tx_last", 32'(tx_last), 32'(beat_idx == exp_len - 1));
            end else begin
               chk("extra_beat", 32'(beat_idx), 32'(exp_len));
            end
            chk("bytes_sent_res", 32'(bytes_sent_res), 32'(beat_idx));
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
            last_data = tx_data;
            if (tx_last) n_last++;
            beat_idx++;
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         prev_last  = tx_last;
         if (done_valid) begin
            n_done++;
            done_cyc = cyc;
            last_done_slot = done_slot;
         end
         if (error) begin
            n_err++;
            err_cyc = cyc;
         end
      end
   end

   task automatic new_frame(input int len);
      exp_len = len;
      clr_req = ~clr_req;
      @(negedge clk);
      #1;
   endtask

   task automatic send_req(input logic [1:0] s, output int acc);
      bit r = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b1;
      req_slot  = s;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         r = req_ready;
         @(posedge clk);
         #1;
         if (r) break;
      end
      if (!r) chk("req_accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      acc = cyc;
      chk("cur_slot_latched", 32'(cur_slot), 32'(s));
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_end(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (n_done > 0 || n_err > 0) break;
         step(1);
      end
      if (n_done == 0 && n_err == 0) chk("frame_end_timeout", 32'd0, 32'd1);
      step(2);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
      chk({tag, "_tx_last"}, 32'(tx_last), 32'd0);
      chk({tag, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
      chk({tag, "_done_valid"}, 32'(done_valid), 32'd0);
      chk({tag, "_error"}, 32'(error), 32'd0);
      chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
      chk({tag, "_mem_rd_addr"}, 32'(mem_rd_addr), 32'd0);
      chk({tag, "_done_slot"}, 32'(done_slot), 32'd0);
      chk({tag, "_cur_slot"}, 32'(cur_slot), 32'd0);
      chk({tag, "_bytes_sent"}, 32'(bytes_sent_res), 32'd0);
   endtask

   int acc;
   int snap;
   int len;
   int rcvd;
   logic [1:0] slot;

   initial begin
      for (int i = 0; i < MaxBytes; i++) frame_mem[i] = 8'd0;
      new_frame(0);
      step(3);
      check_reset_outputs("rst");
      reset = 1'b0;

      // Basic 4-byte frame from slot 2 with an always-ready sink.
      for (int i = 0; i < 4; i++) frame_mem[i] = 8'hA0 + 8'(i);
      cur_valid = 1'b1; cur_fully_rcvd = 1'b1; cur_bytes_rcvd = 16'd4; ready_mode = 0;
      new_frame(4);
      send_req(2'd2, acc);
      wait_end(100);
      chk("basic_latency", 32'(first_valid_cyc - acc), 32'd3);
      chk("basic_beats", 32'(beat_idx), 32'd4);
      chk("basic_consecutive", 32'(last_beat_cyc - first_beat_cyc), 32'd3);
      chk("basic_last_data", 32'(last_data), 32'hA3);
      chk("basic_n_last", 32'(n_last), 32'd1);
      chk("basic_bytes_sent", 32'(bytes_sent_res), 32'd4);
      chk("basic_n_done", 32'(n_done), 32'd1);
      chk("basic_done_slot", 32'(last_done_slot), 32'd2);
      chk("basic_done_timing", 32'(done_cyc - acc), 32'd7);
      chk("basic_n_err", 32'(n_err), 32'd0);

      // Cut-through: count rises 1->3, last byte held until fully received.
      for (int i = 0; i < 3; i++) frame_mem[i] = 8'($urandom);
      cur_valid = 1'b1; cur_fully_rcvd = 1'b0; cur_bytes_rcvd = 16'd1;
      new_frame(3);
      send_req(2'd0, acc);
      step(5);
      cur_bytes_rcvd = 16'd2;
      step(5);
      cur_bytes_rcvd = 16'd3;
      step(20);
      chk("ct_held_beats", 32'(beat_idx), 32'd2);
      chk("ct_held_no_last", 32'(n_last), 32'd0);
      chk("ct_held_no_done", 32'(n_done), 32'd0);
      cur_fully_rcvd = 1'b1;
      wait_end(50);
      chk("ct_beats", 32'(beat_idx), 32'd3);
      chk("ct_n_last", 32'(n_last), 32'd1);
      chk("ct_n_done", 32'(n_done), 32'd1);
      chk("ct_n_err", 32'(n_err), 32'd0);

      // Maximum-size frame with a randomly stalling sink.
      for (int i = 0; i < MaxBytes; i++) frame_mem[i] = 8'($urandom);
      cur_valid = 1'b1; cur_fully_rcvd = 1'b1; cur_bytes_rcvd = 16'(MaxBytes);
      ready_mode = 1;
      new_frame(MaxBytes);
      send_req(2'd3, acc);
      wait_end(20000);
      chk("max_beats", 32'(beat_idx), 32'd1520);
      chk("max_n_last", 32'(n_last), 32'd1);
      chk("max_bytes_sent", 32'(bytes_sent_res), 32'd1520);
      chk("max_n_done", 32'(n_done), 32'd1);
      chk("max_done_slot", 32'(last_done_slot), 32'd3);
      chk("max_n_err", 32'(n_err), 32'd0);

      // Request on an invalid slot.
      cur_valid = 1'b0; cur_fully_rcvd = 1'b1; cur_bytes_rcvd = 16'd8;
      new_frame(0);
      send_req(2'd1, acc);
      @(negedge clk);
      chk("inv_busy_in_check", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("inv_ready_again", 32'(req_ready), 32'd1);
      step(4);
      chk("inv_n_err", 32'(n_err), 32'd1);
      chk("inv_beats", 32'(beat_idx), 32'd0);
      chk("inv_n_done", 32'(n_done), 32'd0);
      chk("inv_reads", 32'(n_reads), 32'd0);

      // Zero-length frame.
      cur_valid = 1'b1; cur_fully_rcvd = 1'b1; cur_bytes_rcvd = 16'd0;
      new_frame(0);
      send_req(2'd3, acc);
      wait_end(50);
      chk("zero_n_err", 32'(n_err), 32'd1);
      chk("zero_n_done", 32'(n_done), 32'd1);
      chk("zero_same_cycle", 32'(err_cyc), 32'(done_cyc));
      chk("zero_done_slot", 32'(last_done_slot), 32'd3);
      chk("zero_beats", 32'(beat_idx), 32'd0);
      chk("zero_reads", 32'(n_reads), 32'd0);

      // Oversized byte count.
      cur_valid = 1'b1; cur_fully_rcvd = 1'b1; cur_bytes_rcvd = 16'd1521;
      new_frame(0);
      send_req(2'd2, acc);
      wait_end(50);
      chk("big_n_err", 32'(n_err), 32'd1);
      chk("big_n_done", 32'(n_done), 32'd0);
      chk("big_beats", 32'(beat_idx), 32'd0);
      chk("big_reads", 32'(n_reads), 32'd0);
      chk("big_idle", 32'(req_ready), 32'd1);

      // cur_valid drops after 10 bytes of a 64-byte frame.
      for (int i = 0; i < 64; i++) frame_mem[i] = 8'($urandom);
      cur_valid = 1'b1; cur_fully_rcvd = 1'b1; cur_bytes_rcvd = 16'd64;
      new_frame(64);
      send_req(2'd1, acc);
      for (int i = 0; i < 500 && beat_idx < 10; i++) step(1);
      cur_valid = 1'b0;
      wait_end(50);
      chk("drop_n_err", 32'(n_err), 32'd1);
      chk("drop_n_last", 32'(n_last), 32'd0);
      chk("drop_n_done", 32'(n_done), 32'd0);
      chk("drop_partial", 32'(beat_idx >= 10 && beat_idx < 64), 32'd1);
      chk("drop_idle", 32'(req_ready), 32'd1);

      // Reset in the middle of a new frame.
      cur_valid = 1'b1;
      new_frame(64);
      send_req(2'd2, acc);
      for (int i = 0; i < 500 && beat_idx < 5; i++) step(1);
      reset = 1'b1;
      step(1);
      check_reset_outputs("midrst");
      reset = 1'b0;
      snap = beat_idx;
      step(30);
      chk("midrst_no_beats", 32'(beat_idx), 32'(snap));
      chk("midrst_no_done", 32'(n_done), 32'd0);

      // Random cut-through frames with a random sink.
      ready_mode = 1;
      for (int f = 0; f < 12; f++) begin
         len  = $urandom_range(1, 48);
         slot = 2'($urandom_range(0, 3));
         rcvd = $urandom_range(0, len);
         for (int i = 0; i < len; i++) frame_mem[i] = 8'($urandom);
         cur_valid = 1'b1; cur_fully_rcvd = 1'b0; cur_bytes_rcvd = 16'(rcvd);
         new_frame(len);
         send_req(slot, acc);
         for (int i = 0; i < 3000; i++) begin
            if (n_done > 0 || n_err > 0) break;
            step(1);
            if (rcvd < len) begin
               if ($urandom_range(0, 2) == 0) rcvd++;
            end else if (!cur_fully_rcvd && $urandom_range(0, 3) == 0) begin
               cur_fully_rcvd = 1'b1;
            end
            cur_bytes_rcvd = 16'(rcvd);
         end
         wait_end(100);
         chk("rnd_beats", 32'(beat_idx), 32'(len));
         chk("rnd_n_last", 32'(n_last), 32'd1);
         chk("rnd_n_done", 32'(n_done), 32'd1);
         chk("rnd_done_slot", 32'(last_done_slot), 32'(slot));
         chk("rnd_n_err", 32'(n_err), 32'd0);
         chk("rnd_bytes_sent", 32'(bytes_sent_res), 32'(len));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/prt_frame_sender.md
PRT_FRAME_SENDER -- requirements
Module: prt_frame_sender

Interface
REQ-001 The block SHALL have these parameters: INDEX_SIZE=2 (slot index width); TABLE_SIZE=4 (PRT slots); BRAM_MEMORY_SIZE=1520 (max frame bytes); BRAM_ADDR_SIZE=16 (byte address/count width); BRAM_DATA_SIZE=8 (byte width).
REQ-002 The block SHALL use one clock, with a synchronous, active-high reset.
REQ-003 The block SHALL have these ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  start-read request.
- req_slot  in  INDEX_SIZE  slot to transmit.
- req_ready  out  1  request accepted when req_valid && req_ready.
- cur_slot  out  INDEX_SIZE  slot being served; drives the PRT status mux.
- cur_valid  in  1  PRT valid bit of cur_slot.
- cur_fully_rcvd  in  1  PRT is_frame_fully_rcvd of cur_slot.
- cur_bytes_rcvd  in  16  PRT bytes_rcvd of cur_slot.
- mem_rd_en  out  1  frame byte read strobe.
- mem_rd_addr  out  16  byte index within the slot frame.
- mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en.
- tx_valid  out  1  output byte valid.
- tx_data  out  8  output byte.
- tx_last  out  1  final byte of the frame.
- tx_ready  in  1  sink accepts the byte when tx_valid && tx_ready.
- bytes_sent_res  out  16  bytes handed to the sink in the current frame.
- done_valid  out  1  one-cycle pulse; the PRT invalidates done_slot.
- done_slot  out  INDEX_SIZE  slot completed.
- error  out  1  one-cycle pulse on abort or illegal frame.

Function
REQ-004 The FSM SHALL have states IDLE, CHECK, STREAM, FINISH; req_ready SHALL be 1 only in IDLE.
REQ-005 In IDLE, an accepted request SHALL latch req_slot into cur_slot, clear the counters, and move to CHECK.
REQ-006 In CHECK, if !cur_valid, the block SHALL pulse error and return to IDLE with no done_valid; otherwise it SHALL enter STREAM.
REQ-007 In STREAM (cut-through), the block SHALL issue a read at rd_ptr (0..BRAM_MEMORY_SIZE-1) when both of the following hold:
- rd_ptr < cur_bytes_rcvd-1, or (rd_ptr == cur_bytes_rcvd-1 and cur_fully_rcvd);
- in-flight reads plus buffered bytes < 2.
REQ-008 The tx_last tag SHALL be fixed at issue time: 1 if and only if rd_ptr == cur_bytes_rcvd-1 and cur_fully_rcvd.
REQ-009 Returned bytes SHALL enter a 2-entry buffer holding {last, data}; tx_valid SHALL mean the buffer is not empty.
REQ-010 Bytes SHALL leave in address order with no loss or duplication under any tx_ready pattern; tx_data/tx_last SHALL be stable while tx_valid && !tx_ready.
REQ-011 bytes_sent_res SHALL increment by 1 on each tx handshake; all counters SHALL be 16-bit.
REQ-012 After the handshake of the byte tagged last, the FSM SHALL go to FINISH.
REQ-013 FINISH SHALL pulse done_valid for exactly 1 cycle with done_slot=cur_slot, then return to IDLE.
REQ-014 Latency: the first tx_valid SHALL rise 3 cycles after request acceptance when the data is available and the buffer is empty (CHECK, issue, data return).
REQ-015 Zero-length frame (cur_fully_rcvd && cur_bytes_rcvd==0 in STREAM): the block SHALL produce no tx beats, SHALL pulse error and done_valid in the same cycle, and SHALL return to IDLE.
REQ-016 If cur_bytes_rcvd > BRAM_MEMORY_SIZE, the block SHALL pulse error, flush, and return to IDLE with no done_valid.
REQ-017 If cur_valid drops in STREAM, the block SHALL stop issuing reads, discard the buffer and in-flight data, pulse error, and return to IDLE with no done_valid and no tx_last.
REQ-018 If cur_bytes_rcvd stalls while !cur_fully_rcvd, the block SHALL wait indefinitely with the last available byte withheld.

Reset
REQ-019 On reset, the state SHALL be IDLE and cur_slot, rd_ptr and bytes_sent_res SHALL be 0.
REQ-020 On reset, the buffer SHALL be empty and in-flight reads discarded.
REQ-021 On reset, req_ready SHALL be 1; tx_valid, tx_last, mem_rd_en, done_valid and error SHALL be 0; tx_data, mem_rd_addr and done_slot SHALL be 0.
REQ-022 Reset mid-frame SHALL emit no further beats and no done_valid.

Structure
REQ-023 Package prt_pkg SHALL hold the parameter constants and the FSM state enum, shared with the PRT block.
REQ-024 The output buffer SHALL be a sub-module prt_skid_fifo (2 entries, 9-bit width, with full/empty flags).

Verification
REQ-025 Slot 2, valid, fully received, 4 bytes A0..A3, tx_ready=1 -> A0..A3 on consecutive cycles, tx_last on A3, bytes_sent_res=4, done_valid with done_slot=2.
REQ-026 Cut-through: bytes_rcvd rises 1->3 one byte every 5 cycles, then fully_rcvd -> the third byte is held until fully_rcvd, then sent with tx_last=1.
REQ-027 1520-byte frame with tx_ready toggling at random 50% -> all 1520 bytes emitted in order, one tx_last, bytes_sent_res=1520.
REQ-028 Request slot 1 with cur_valid=0 -> error pulse, no tx beats, no done_valid, req_ready=1 again after 2 cycles.
REQ-029 cur_valid drops after 10 bytes of a 64-byte frame -> error pulse, no tx_last, FSM in IDLE; then reset mid-frame on a new request -> all outputs at reset values on the next cycle.
